// File: rtl/output_result_buffer.sv
// Double-buffered multi-lane result store: rescales NUM_LANES signed results per beat and ping-pongs two banks between writer and reader.
// Latency: accepted beat written on the accepting edge, readable after its swap; read data 1 cycle after read_en.
// Backpressure: result_ready drops when the fill bank is full or a swap is waiting; a beat offered then is dropped and overflow is set.
module output_result_buffer #(
    parameter int DATA_WIDTH   = 8,
    parameter int VECTOR_WIDTH = 4,
    parameter int NUM_LANES    = 2,
    parameter int ADDR_WIDTH   = 5,
    parameter int MEM_SIZE     = 32,
    parameter int RESULT_WIDTH = 2*DATA_WIDTH + $clog2(VECTOR_WIDTH),
    parameter int SHIFT_WIDTH  = $clog2(RESULT_WIDTH)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_LANES*RESULT_WIDTH-1:0] dot_product_result,
    input  logic                              result_valid,
    output logic                              result_ready,
    input  logic                              processing_done,
    input  logic [SHIFT_WIDTH-1:0]            shift_amt,
    input  logic                              sat_en,
    input  logic                              clear_flags,
    input  logic                              read_en,
    input  logic [ADDR_WIDTH-1:0]             read_addr,
    input  logic                              bank_release,
    output logic [DATA_WIDTH-1:0]             result_out,
    output logic                              read_valid,
    output logic                              bank_ready,
    output logic [ADDR_WIDTH:0]               ready_count,
    output logic                              writer_busy,
    output logic                              writer_done,
    output logic                              overflow,
    output logic                              sat_flag
);

    localparam int PTR_W     = ADDR_WIDTH + 1;
    localparam int MEM_WORDS = 2 * MEM_SIZE;
    localparam int MEM_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    // Saturation bounds expressed at result width so comparisons stay signed.
    localparam int SMAX = (2 ** (DATA_WIDTH - 1)) - 1;
    localparam logic signed [RESULT_WIDTH-1:0] SAT_MAX = RESULT_WIDTH'(SMAX);
    localparam logic signed [RESULT_WIDTH-1:0] SAT_MIN = RESULT_WIDTH'(-SMAX - 1);
    localparam logic [DATA_WIDTH-1:0] WORD_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] WORD_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        SWAP_WAIT = 2'd2
    } state_t;

    // Both banks live in one array: bank b occupies words [b*MEM_SIZE +: MEM_SIZE].
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    state_t                state_q,        state_d;
    logic [PTR_W-1:0]      wptr_q,         wptr_d;
    logic                  wr_bank_q,      wr_bank_d;
    logic                  bank_ready_q,   bank_ready_d;
    logic [PTR_W-1:0]      ready_count_q,  ready_count_d;
    logic                  writer_done_q,  writer_done_d;
    logic                  overflow_q,     overflow_d;
    logic                  sat_flag_q,     sat_flag_d;
    logic [DATA_WIDTH-1:0] result_out_q,   result_out_d;
    logic                  read_valid_q,   read_valid_d;

    logic signed [RESULT_WIDTH-1:0] lane_res   [NUM_LANES];
    logic signed [RESULT_WIDTH-1:0] lane_shr   [NUM_LANES];
    logic        [DATA_WIDTH-1:0]   lane_word  [NUM_LANES];
    logic        [MEM_AW-1:0]       wr_idx     [NUM_LANES];
    logic        [NUM_LANES-1:0]    lane_clamp;

    logic                  accept;
    logic                  swap;
    logic [PTR_W-1:0]      wptr_acc;
    logic [MEM_AW-1:0]     rd_idx;

    // Ready only while a whole beat still fits and no swap is pending.
    assign result_ready = (state_q != SWAP_WAIT) && ((int'(wptr_q) + NUM_LANES) <= MEM_SIZE);
    assign accept       = result_valid && result_ready;
    assign wptr_acc     = accept ? (wptr_q + PTR_W'(NUM_LANES)) : wptr_q;

    // Per-lane rescale: arithmetic shift, then clamp or truncate to the stored width.
    always_comb begin
        lane_clamp = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_res[k]  = $signed(dot_product_result[k*RESULT_WIDTH +: RESULT_WIDTH]);
            lane_shr[k]  = lane_res[k] >>> shift_amt;
            lane_word[k] = lane_shr[k][DATA_WIDTH-1:0];
            wr_idx[k]    = MEM_AW'((wr_bank_q ? MEM_SIZE : 0) + int'(wptr_q) + k);
            if (sat_en) begin
                if (lane_shr[k] > SAT_MAX) begin
                    lane_word[k]  = WORD_MAX;
                    lane_clamp[k] = 1'b1;
                end else if (lane_shr[k] < SAT_MIN) begin
                    lane_word[k]  = WORD_MIN;
                    lane_clamp[k] = 1'b1;
                end
            end
        end
    end

    // Writer FSM next state, bank handover, release and sticky flags.
    always_comb begin
        state_d       = state_q;
        wptr_d        = wptr_acc;
        wr_bank_d     = wr_bank_q;
        bank_ready_d  = bank_ready_q;
        ready_count_d = ready_count_q;
        writer_done_d = 1'b0;
        swap          = 1'b0;

        case (state_q)
            IDLE: begin
                // A done pulse with nothing written is ignored.
                if (accept) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                // The registered bank_ready is used, so a release on this same
                // edge still routes through SWAP_WAIT.
                if (processing_done) begin
                    if (!bank_ready_q) begin
                        swap    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = SWAP_WAIT;
                    end
                end
            end
            SWAP_WAIT: begin
                if (!bank_ready_q) begin
                    swap    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (swap) begin
            // wptr_acc includes a beat accepted alongside processing_done.
            bank_ready_d  = 1'b1;
            ready_count_d = wptr_acc;
            wr_bank_d     = ~wr_bank_q;
            wptr_d        = '0;
            writer_done_d = 1'b1;
        end else if (bank_release && bank_ready_q) begin
            bank_ready_d  = 1'b0;
            ready_count_d = '0;
        end

        // Clearing wins over a set in the same cycle.
        overflow_d = overflow_q | (result_valid && !result_ready);
        sat_flag_d = sat_flag_q | (accept && (|lane_clamp));
        if (clear_flags) begin
            overflow_d = 1'b0;
            sat_flag_d = 1'b0;
        end
    end

    // Read port: words beyond ready_count read back as zero.
    always_comb begin
        rd_idx       = MEM_AW'((wr_bank_q ? 0 : MEM_SIZE) + int'(read_addr));
        result_out_d = result_out_q;
        read_valid_d = 1'b0;
        if (read_en && bank_ready_q) begin
            read_valid_d = 1'b1;
            if ({1'b0, read_addr} >= ready_count_q) begin
                result_out_d = '0;
            end else begin
                result_out_d = mem[rd_idx];
            end
        end
    end

    // Storage is not reset; all lanes of an accepted beat land on the same edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                mem[wr_idx[k]] <= lane_word[k];
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wptr_q        <= '0;
            wr_bank_q     <= 1'b0;
            bank_ready_q  <= 1'b0;
            ready_count_q <= '0;
            writer_done_q <= 1'b0;
            overflow_q    <= 1'b0;
            sat_flag_q    <= 1'b0;
            result_out_q  <= '0;
            read_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            wr_bank_q     <= wr_bank_d;
            bank_ready_q  <= bank_ready_d;
            ready_count_q <= ready_count_d;
            writer_done_q <= writer_done_d;
            overflow_q    <= overflow_d;
            sat_flag_q    <= sat_flag_d;
            result_out_q  <= result_out_d;
            read_valid_q  <= read_valid_d;
        end
    end

    assign result_out  = result_out_q;
    assign read_valid  = read_valid_q;
    assign bank_ready  = bank_ready_q;
    assign ready_count = ready_count_q;
    assign writer_busy = (state_q != IDLE);
    assign writer_done = writer_done_q;
    assign overflow    = overflow_q;
    assign sat_flag    = sat_flag_q;

endmodule
